// File: rtl/bcd_counter_nd_if.sv
// Count/load bus of the N-digit BCD counter: control and load value in, count and flags out.
// The interface parameter must match the DIGITS of the counter it is bound to.
interface bcd_counter_nd_if #(
  parameter int unsigned DIGITS = 6
);
  logic                  ena;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   d;
  logic [4*DIGITS-1:0]   q;
  logic                  carry;
  logic                  ovf;
  logic                  lderr;

  modport master (
    output ena, up, load, d,
    input  q, carry, ovf, lderr
  );

  modport slave (
    input  ena, up, load, d,
    output q, carry, ovf, lderr
  );
endinterface

// File: rtl/bcd_counter_nd.sv
// N-digit packed-BCD up/down counter with parallel load, terminal-count pulse,
// sticky overflow flag and selectable wrap/saturate at the terminal count.
module bcd_counter_nd #(
  parameter int unsigned DIGITS   = 6,
  parameter bit          SATURATE = 1'b0
) (
  input logic             f_in,
  input logic             clr_n,
  bcd_counter_nd_if.slave bus
);

  localparam int unsigned Width = 4 * DIGITS;

  logic [Width-1:0]  q_q, q_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic              lderr_q, lderr_d;

  logic [Width-1:0]  inc_val, dec_val;
  logic [DIGITS-1:0] nine, zero, d_bad;
  logic [DIGITS-1:0] inc_c, dec_b;
  logic              all_nine, all_zero, d_legal;

  // Ripple chains: a digit steps only when every lower digit is at its wrap value.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] dig;
    assign dig      = q_q[4*i +: 4];
    assign nine[i]  = (dig == 4'd9);
    assign zero[i]  = (dig == 4'd0);
    assign d_bad[i] = (bus.d[4*i +: 4] > 4'd9);

    if (i == 0) begin : g_lsd
      assign inc_c[i] = 1'b1;
      assign dec_b[i] = 1'b1;
    end else begin : g_upper
      assign inc_c[i] = inc_c[i-1] & nine[i-1];
      assign dec_b[i] = dec_b[i-1] & zero[i-1];
    end

    assign inc_val[4*i +: 4] = !inc_c[i] ? dig : (nine[i] ? 4'd0 : dig + 4'd1);
    assign dec_val[4*i +: 4] = !dec_b[i] ? dig : (zero[i] ? 4'd9 : dig - 4'd1);
  end

  assign all_nine = &nine;
  assign all_zero = &zero;
  assign d_legal  = ~|d_bad;

  always_comb begin
    q_d     = q_q;
    ovf_d   = ovf_q;
    carry_d = 1'b0;
    lderr_d = 1'b0;
    if (bus.load) begin
      if (d_legal) begin
        q_d   = bus.d;
        ovf_d = 1'b0;
      end else begin
        lderr_d = 1'b1;
      end
    end else if (bus.ena) begin
      if (bus.up) begin
        // Free-running wrap from all 9s to all 0s falls out of the ripple chain.
        if (!(all_nine && SATURATE)) q_d = inc_val;
        if (all_nine) begin
          carry_d = 1'b1;
          ovf_d   = 1'b1;
        end
      end else begin
        if (!(all_zero && SATURATE)) q_d = dec_val;
        if (all_zero) begin
          carry_d = 1'b1;
          ovf_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge f_in or negedge clr_n) begin
    if (!clr_n) begin
      q_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      lderr_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      lderr_q <= lderr_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.carry = carry_q;
  assign bus.ovf   = ovf_q;
  assign bus.lderr = lderr_q;

endmodule

// File: doc/bcd_counter_nd.md
# bcd_counter_nd

Parametrised N-digit packed-BCD up/down counter with parallel load, terminal-count pulse and sticky overflow flag. Next generation of the team's fixed 6-digit BCD frequency counter: digit count is a parameter, counting is bidirectional, and wrap/saturate behaviour is selectable. Sits behind the gated input stage of the frequency meter. Q feeds the display latch/decoder; CARRY cascades to a further counter stage.

## Interface
- DIGITS, 6: number of BCD digits; legal range 1..8.
- SATURATE, 0: 0 = wrap at the terminal count; 1 = hold at the terminal count.
- F_IN  input  1  counting clock; all state updates on its rising edge.
- CLR_N  input  1  asynchronous, active-low reset.
- ENA  input  1  count enable.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LOAD  input  1  synchronous parallel load request.
- D  input  4*DIGITS  packed BCD load value; digit 0 is in D[3:0].
- Q  output  4*DIGITS  packed BCD count; digit 0 is in Q[3:0].
- CARRY  output  1  one-cycle pulse when the count reaches or attempts to pass a terminal count.
- OVF  output  1  sticky overflow/underflow flag.
- LDERR  output  1  one-cycle pulse on a rejected load.

## Operation
- Reset: while CLR_N = 0, Q = 0, CARRY = 0, OVF = 0 and LDERR = 0, without regard to F_IN.
- Priority per edge is CLR_N, then LOAD, then ENA, then hold.
- LOAD with every nibble of D at 9 or below:
  - Q <= D.
  - OVF <= 0.
  - CARRY = 0.
  - ENA is ignored that cycle.
- LOAD with any nibble of D above 9:
  - Q holds and OVF holds.
  - LDERR = 1 for that cycle.
  - ENA is ignored that cycle.
- Increment (ENA = 1, UP = 1):
  - Digit 0 +1.
  - A digit at 9 becomes 0 and carries into the next digit.
  - Carry ripples combinationally through all digits within one cycle.
- Decrement (ENA = 1, UP = 0):
  - Digit 0 -1.
  - A digit at 0 becomes 9 and borrows from the next digit.
- Terminal counts: all digits 9 when counting up; all digits 0 when counting down.
- Increment at the up terminal (all 9s):
  - SATURATE = 0: Q <= 0.
  - SATURATE = 1: Q holds.
  - In both modes CARRY = 1 and OVF <= 1.
- Decrement at the down terminal (all 0s):
  - SATURATE = 0: Q <= all 9s.
  - SATURATE = 1: Q holds.
  - In both modes CARRY = 1 and OVF <= 1.
- OVF is cleared only by reset or by a successful load.
- ENA = 0 with no LOAD: Q and OVF hold; CARRY = 0 and LDERR = 0.
- Q never holds a nibble above 9 by construction, so no illegal-state recovery is needed.
- UP may change on any cycle; it is sampled only on the edge where it is used.

## Timing
- All outputs are registered: they change only on a F_IN rising edge or on CLR_N assertion.
- Latency is one edge. Inputs sampled at edge k are reflected on Q, CARRY, OVF and LDERR after edge k.
- CARRY and LDERR are high for exactly the one cycle following the triggering edge.
- Back-to-back terminal events produce CARRY every cycle, for example a saturated counter with ENA held high.
- Reset assertion mid-count takes effect immediately.
- Reset release is synchronised outside this block. The first edge after release counts normally from 0.
- LOAD and ENA on the same edge: the load wins and no count occurs.
- Critical path is the DIGITS-deep BCD carry/borrow chain. It must meet timing at DIGITS = 8.

## Test plan
- DIGITS = 6, SATURATE = 0, count up:
  - From Q = 0x000009, ENA = 1, UP = 1, one edge -> Q = 0x000010, CARRY = 0.
  - From Q = 0x099999, one edge -> Q = 0x100000.
- Wrap up: LOAD D = 0x999998, then 2 edges with ENA = 1, UP = 1 -> Q = 0x999999, then 0x000000 with CARRY = 1 for one cycle and OVF = 1. A further edge -> Q = 0x000001, CARRY = 0, OVF still 1.
- Wrap down: Q = 0x000000, UP = 0, ENA = 1, one edge -> Q = 0x999999, CARRY = 1, OVF = 1. Next edge -> Q = 0x999998.
- Load: LOAD D = 0x12A456 -> Q unchanged, LDERR = 1 for one cycle. Then LOAD D = 0x123456 with ENA = 1 -> Q = 0x123456, OVF = 0, no count.
- Saturate: SATURATE = 1, DIGITS = 4, LOAD 0x9999, ENA = 1, UP = 1 for 3 edges -> Q stays 0x9999, CARRY high all 3 cycles, OVF = 1.
- Async reset: CLR_N low mid-cycle during counting -> Q = 0, OVF = 0 and CARRY = 0 immediately, without waiting for a F_IN edge. Hold CLR_N low over several edges -> no counting. After release -> counts 1, 2, 3.
